// File: rtl/l2_i_controller_if.sv
// L1-I <-> L2 <-> memory handshake bundle for the L2 instruction controller.
// slave = controller side, master = requester/memory/testbench side.
interface l2_i_controller_if;
    logic        read_L1_L2;
    logic [51:0] tag_L1_L2;
    logic [5:0]  index_L1_L2;
    logic        flush;
    logic        ready_MEM_L2;
    logic        ready_L2_L1;
    logic        read_L2_MEM;
    logic [57:0] addr_L2_MEM;
    logic        refill_L2;
    logic [6:0]  set_idx;
    logic        way_sel;

    modport slave (
        input  read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
        output ready_L2_L1, read_L2_MEM, addr_L2_MEM, refill_L2, set_idx, way_sel
    );

    modport master (
        output read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
        input  ready_L2_L1, read_L2_MEM, addr_L2_MEM, refill_L2, set_idx, way_sel
    );
endinterface

// File: rtl/l2_i_controller.sv
// 2-way/128-set L2 instruction tag controller; hit responds 2 cycles after the read
// sample, miss 2 cycles after ready_MEM_L2. Memory read is a level held until ready_MEM_L2.
module l2_i_controller (
    input  logic              clk,
    input  logic              rst,
    l2_i_controller_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPARE = 3'd1;
    localparam logic [2:0] S_MEM_REQ = 3'd2;
    localparam logic [2:0] S_REFILL  = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    logic [2:0]   r_state;
    logic [57:0]  r_la;
    logic         r_way;
    logic         r_flush_pend;
    logic [127:0] r_valid0;
    logic [127:0] r_valid1;
    logic [127:0] r_lru;
    logic [50:0]  r_tag0 [128];
    logic [50:0]  r_tag1 [128];

    logic [6:0]   w_set;
    logic [50:0]  w_stag;
    logic         w_hit0;
    logic         w_hit1;
    logic         w_victim;

    assign w_set    = r_la[6:0];
    assign w_stag   = r_la[57:7];
    assign w_hit0   = r_valid0[w_set] && (r_tag0[w_set] == w_stag);
    assign w_hit1   = r_valid1[w_set] && (r_tag1[w_set] == w_stag);
    // Invalid ways fill first (way 0 preferred); lru only decides between two live lines.
    assign w_victim = !r_valid0[w_set] ? 1'b0 :
                      !r_valid1[w_set] ? 1'b1 : r_lru[w_set];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_la         <= '0;
            r_way        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_valid0     <= '0;
            r_valid1     <= '0;
            r_lru        <= '0;
        end else begin
            if (bus.flush && (r_state != S_IDLE) && (r_state != S_FLUSH))
                r_flush_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.flush || r_flush_pend) begin
                        r_state <= S_FLUSH;
                    end else if (bus.read_L1_L2) begin
                        r_la    <= {bus.tag_L1_L2, bus.index_L1_L2};
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit0 || w_hit1) begin
                        r_way        <= !w_hit0;
                        r_lru[w_set] <= w_hit0;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_way   <= w_victim;
                        r_state <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (bus.ready_MEM_L2)
                        r_state <= S_REFILL;
                end
                S_REFILL: begin
                    if (r_way)
                        r_valid1[w_set] <= 1'b1;
                    else
                        r_valid0[w_set] <= 1'b1;
                    r_lru[w_set] <= !r_way;
                    r_state      <= S_RESPOND;
                end
                S_RESPOND: r_state <= S_IDLE;
                S_FLUSH: begin
                    r_valid0     <= '0;
                    r_valid1     <= '0;
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag storage needs no reset: entries are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_REFILL)) begin
            if (r_way)
                r_tag1[w_set] <= w_stag;
            else
                r_tag0[w_set] <= w_stag;
        end
    end

    assign bus.ready_L2_L1 = (r_state == S_RESPOND);
    assign bus.read_L2_MEM = (r_state == S_MEM_REQ);
    assign bus.refill_L2   = (r_state == S_REFILL);
    assign bus.addr_L2_MEM = r_la;
    assign bus.set_idx     = w_set;
    assign bus.way_sel     = r_way;
endmodule
